// File: rtl/idli_utx_m.sv
// UART transmitter: pairs flagged execute-stage nibbles into bytes, queues them
// in a small FIFO and serialises each byte 8N1, LSB first, on a registered line.
module idli_utx_m #(
    parameter int DIV   = 16,
    parameter int DEPTH = 4
) (
    input  logic       i_utx_gck,
    input  logic       i_utx_rst,
    input  logic [3:0] i_utx_data,
    input  logic       i_utx_vld,
    output logic       o_utx_full,
    output logic       o_utx_busy,
    output logic       o_utx_ovf,
    output logic       o_utx_tx
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DIV);

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic          half;
    logic [3:0]    lo_nib;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    shift;
    logic          ovf;
    logic          tx;

    logic       push;
    logic       push_ok;
    logic       pop;
    logic       baud_done;
    logic [7:0] byte_in;

    assign push      = i_utx_vld && half;
    assign push_ok   = push && (count != DEPTH_C);
    assign pop       = (state == ST_IDLE) && (count != '0);
    assign baud_done = (baud == BAUD_LAST);
    assign byte_in   = {i_utx_data, lo_nib};

    assign o_utx_full = (count == DEPTH_C);
    assign o_utx_busy = (state != ST_IDLE) || (count != '0);
    assign o_utx_ovf  = ovf;
    assign o_utx_tx   = tx;

    // Pairing, FIFO bookkeeping and the serialiser share one control register set.
    always_ff @(posedge i_utx_gck) begin
        if (i_utx_rst) begin
            half    <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf     <= 1'b0;
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            if (i_utx_vld)
                half <= ~half;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (push && !push_ok)
                ovf <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        state <= ST_START;
                        baud  <= '0;
                        tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        baud  <= '0;
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    baud  <= '0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Payload storage needs no reset; it is only read behind valid control state.
    always_ff @(posedge i_utx_gck) begin
        if (i_utx_vld && !half)
            lo_nib <= i_utx_data;
        if (push_ok)
            mem[wr_ptr] <= byte_in;
        if (pop)
            shift <= mem[rd_ptr];
    end

endmodule

// File: tb/tb_idli_utx_m.sv
// Randomised and directed bench for idli_utx_m against a frame-timer reference model.
module tb_idli_utx_m;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld;
    logic [3:0] data;
    logic       full;
    logic       busy;
    logic       ovf;
    logic       tx;

    always #5 clk = ~clk;

    idli_utx_m #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .i_utx_gck  (clk),
        .i_utx_rst  (rst),
        .i_utx_data (data),
        .i_utx_vld  (vld),
        .o_utx_full (full),
        .o_utx_busy (busy),
        .o_utx_ovf  (ovf),
        .o_utx_tx   (tx)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a byte queue plus a frame timer counting cycles since the pop.
    logic       m_half;
    logic [3:0] m_lo;
    logic [7:0] m_q [$];
    logic       m_act;
    int         m_t;
    logic [7:0] m_cur;
    logic       m_ovf;
    logic       m_line;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic model_step();
        int   sz;
        logic old_act;
        if (rst) begin
            m_q.delete();
            m_half = 1'b0;
            m_act  = 1'b0;
            m_t    = 0;
            m_ovf  = 1'b0;
        end else begin
            sz      = m_q.size();
            old_act = m_act;
            if (!old_act) begin
                if (sz != 0) begin
                    m_cur = m_q.pop_front();
                    m_act = 1'b1;
                    m_t   = 0;
                end
            end else begin
                m_t++;
                if (m_t == 10 * DIV) m_act = 1'b0;
            end
            if (vld) begin
                if (!m_half) begin
                    m_lo   = data;
                    m_half = 1'b1;
                end else begin
                    if (sz < DEPTH) m_q.push_back({data, m_lo});
                    else m_ovf = 1'b1;
                    m_half = 1'b0;
                end
            end
        end
        m_line = m_act ? frame_bit(m_cur, m_t / DIV) : 1'b1;
    endtask

    task automatic cycle(input logic r, input logic v, input logic [3:0] d);
        rst  = r;
        vld  = v;
        data = d;
        model_step();
        @(posedge clk);
        #1;
        chk("tx",   tx,   m_line);
        chk("busy", busy, m_act || (m_q.size() != 0));
        chk("full", full, m_q.size() == DEPTH);
        chk("ovf",  ovf,  m_ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'($urandom));
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b0, 1'b1, b[3:0]);
        cycle(1'b0, 1'b1, b[7:4]);
    endtask

    initial begin
        logic [9:0] fr;

        cycle(1'b1, 1'b0, 4'h0);
        cycle(1'b1, 1'b1, 4'h7);
        chk("rst_tx",   tx,   1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_ovf",  ovf,  1'b0);
        idle(3);

        // Single byte 0x5A: start, 0,1,0,1,1,0,1,0, stop, DIV cycles each.
        fr = {1'b1, 8'h5A, 1'b0};
        cycle(1'b0, 1'b1, 4'hA);
        cycle(1'b0, 1'b1, 4'h5);
        for (int k = 0; k < 10 * DIV; k++) begin
            cycle(1'b0, 1'b0, 4'h0);
            chk("seq5A", tx, fr[k / DIV]);
        end
        cycle(1'b0, 1'b0, 4'h0);
        chk("seq5A_idle", busy, 1'b0);
        idle(3);

        // Gapped nibbles form 0xC3 only after the second one.
        cycle(1'b0, 1'b1, 4'h3);
        idle(3);
        chk("gap_busy", busy, 1'b0);
        cycle(1'b0, 1'b1, 4'hC);
        idle(10 * DIV + 4);

        // Overflow: six bytes back-to-back, the last one dropped.
        for (int b = 0; b < 6; b++) send(8'(b));
        chk("ovf_set",  ovf,  1'b1);
        chk("ovf_full", full, 1'b1);
        idle(10 * DIV * 6);
        chk("ovf_stay", ovf, 1'b1);

        // Back-to-back frames.
        send(8'h81);
        send(8'h7E);
        idle(10 * DIV * 2 + 6);

        // Reset during data bit 3 of 0xFF, then a clean 0x55.
        send(8'hFF);
        idle(4 * DIV + 2);
        cycle(1'b1, 1'b0, 4'h0);
        chk("mid_tx",   tx,   1'b1);
        chk("mid_busy", busy, 1'b0);
        chk("mid_ovf",  ovf,  1'b0);
        send(8'h55);
        idle(10 * DIV + 4);

        // Odd nibble before reset is forgotten.
        cycle(1'b0, 1'b1, 4'h1);
        cycle(1'b1, 1'b0, 4'h0);
        send(8'h32);
        idle(10 * DIV + 4);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 249) == 0), ($urandom_range(0, 2) == 0), 4'($urandom));
        idle(10 * DIV * (DEPTH + 2));
        chk("drain_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
